mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs; contains the MEM/WB pipeline register.
- Performs data-memory reads and writes over a req/ack handshake to a variable-latency data memory.
- Drives a stall to freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
- Inserts bubbles into MEM/WB during the stall; forwards non-memory instructions in one cycle.

Parameters:
- TIMEOUT, 255: max cycles in WAIT without ack before abort; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- RegWrite_in  input  1  WB control from EX/MEM
- MemtoReg_in  input  1  WB control from EX/MEM
- MemRead_in  input  1  load request from EX/MEM
- MemWrite_in  input  1  store request from EX/MEM
- ALUData_in  input  32  ALU result / byte address
- MemWriteData_in  input  32  store data
- WBregister_in  input  5  destination register
- mem_req  output  1  data-memory request, registered
- mem_we  output  1  1 = write, 0 = read, registered
- mem_addr  output  32  word-aligned address, registered
- mem_wdata  output  32  store data, registered
- mem_rdata  input  32  read data, valid with mem_ack
- mem_ack  input  1  one-cycle completion pulse
- stall  output  1  combinational; freeze upstream stages and EX/MEM
- mem_err  output  1  one-cycle pulse on misalignment, dual-request conflict or timeout
- RegWrite_out  output  1  MEM/WB
- MemtoReg_out  output  1  MEM/WB
- ReadData_out  output  32  MEM/WB load data
- ALUData_out  output  32  MEM/WB
- WBregister_out  output  5  MEM/WB

Behaviour:
- Reset (async, rst=0):
  - state IDLE; timeout counter 0.
  - All outputs 0, including mem_req, which drops immediately.
  - Any outstanding access is abandoned; a late mem_ack after reset is ignored.
- access = MemRead_in | MemWrite_in.
- If both MemRead_in and MemWrite_in are 1: treat as a read, suppress the write, pulse mem_err.
- misaligned = access & (ALUData_in[1:0] != 0).
- IDLE, no access:
  - MEM/WB loads RegWrite_in, MemtoReg_in, ALUData_in, WBregister_in; ReadData_out <= 0.
  - stall = 0.
- IDLE, misaligned access:
  - No request issued; mem_err pulses next cycle.
  - MEM/WB loads a bubble: RegWrite_out = 0, MemtoReg_out = 0, others 0.
  - stall = 0.
- IDLE, aligned access:
  - stall = 1 this cycle.
  - Capture mem_addr, mem_wdata, mem_we (= ~read) and the WB fields (RegWrite, MemtoReg, ALUData, WBregister).
  - mem_req <= 1; counter <= 0; go to WAIT.
  - MEM/WB loads a bubble.
- WAIT, mem_ack = 0:
  - stall = 1; counter increments.
  - mem_req and address/data/we held stable.
  - MEM/WB loads a bubble each cycle.
- WAIT, mem_ack = 1:
  - stall = 0; mem_req <= 0; go to IDLE.
  - MEM/WB loads the captured WB fields; ReadData_out <= read ? mem_rdata : 0.
- WAIT timeout (TIMEOUT != 0, counter == TIMEOUT-1, no ack):
  - mem_req <= 0; mem_err pulses; MEM/WB bubble; stall = 0; go to IDLE.
  - A mem_ack arriving in the same cycle wins over the timeout.
- mem_ack outside WAIT is ignored.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory access: stall for 1 + N cycles, where N = cycles from mem_req high to mem_ack, N >= 1.
  - Minimum 2 stall cycles; result appears in MEM/WB at the edge ending the ack cycle.
- Back-to-back accesses:
  - The next access is seen in IDLE the cycle after ack.
  - mem_req is low for at least one cycle between requests.
- The 32-bit datapath passes through without modification; no sign or byte handling.

Test Plan:
- rst low mid-WAIT with mem_req=1 -> mem_req=0 immediately and all MEM/WB outputs 0. After release, an ack pulse is ignored and stall=0.
- Non-memory op (RegWrite=1, ALUData=0x0000_1234, WBreg=5) -> next edge: RegWrite_out=1, ALUData_out=0x1234, WBregister_out=5, ReadData_out=0; stall never 1.
- Load addr 0x100, ack 3 cycles after req, mem_rdata=0xDEADBEEF, WBreg=8, MemtoReg=1:
  - stall high 4 cycles; bubbles in MEM/WB during the stall.
  - Then RegWrite_out=1, MemtoReg_out=1, ReadData_out=0xDEADBEEF, WBregister_out=8.
- Store addr 0x200 data 0xCAFEF00D with ack after 1 cycle:
  - mem_we=1, mem_addr=0x200, mem_wdata=0xCAFEF00D held through WAIT.
  - Stall 2 cycles; RegWrite_out=0.
- Load at addr 0x102 -> no mem_req; mem_err pulse; bubble in MEM/WB; stall=0.
- TIMEOUT=4, never ack:
  - mem_req high 4 cycles, then drops; mem_err pulses; stall released.
  - The following instruction flows normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory access over a req/ack handshake, upstream stall generation,
// and the MEM/WB pipeline register.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] ALUData_in,
    input  logic [31:0] MemWriteData_in,
    input  logic [4:0]  WBregister_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        mem_err,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALUData_out,
    output logic [4:0]  WBregister_out
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cap_regwrite;
    logic               r_cap_memtoreg;
    logic [31:0]        r_cap_alu;
    logic [4:0]         r_cap_wbreg;

    logic               w_access;
    logic               w_dual;
    logic               w_mis;
    logic               w_timeout;

    assign w_access  = MemRead_in | MemWrite_in;
    assign w_dual    = MemRead_in & MemWrite_in;
    assign w_mis     = w_access & (ALUData_in[1:0] != 2'b00);
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == LP_TO_LAST);

    assign stall = ((r_state == S_IDLE) && w_access && !w_mis) ||
                   ((r_state == S_WAIT) && !mem_ack && !w_timeout);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_cap_regwrite <= 1'b0;
            r_cap_memtoreg <= 1'b0;
            r_cap_alu      <= '0;
            r_cap_wbreg    <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_err        <= 1'b0;
            RegWrite_out   <= 1'b0;
            MemtoReg_out   <= 1'b0;
            ReadData_out   <= '0;
            ALUData_out    <= '0;
            WBregister_out <= '0;
        end else begin
            // MEM/WB defaults to a bubble; only completing instructions override it
            mem_err        <= 1'b0;
            RegWrite_out   <= 1'b0;
            MemtoReg_out   <= 1'b0;
            ReadData_out   <= '0;
            ALUData_out    <= '0;
            WBregister_out <= '0;
            case (r_state)
                S_IDLE: begin
                    if (!w_access) begin
                        RegWrite_out   <= RegWrite_in;
                        MemtoReg_out   <= MemtoReg_in;
                        ALUData_out    <= ALUData_in;
                        WBregister_out <= WBregister_in;
                    end else begin
                        mem_err <= w_mis | w_dual;
                        if (!w_mis) begin
                            r_cap_regwrite <= RegWrite_in;
                            r_cap_memtoreg <= MemtoReg_in;
                            r_cap_alu      <= ALUData_in;
                            r_cap_wbreg    <= WBregister_in;
                            mem_req        <= 1'b1;
                            mem_we         <= ~MemRead_in;
                            mem_addr       <= ALUData_in;
                            mem_wdata      <= MemWriteData_in;
                            r_cnt          <= '0;
                            r_state        <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        mem_req        <= 1'b0;
                        r_state        <= S_IDLE;
                        RegWrite_out   <= r_cap_regwrite;
                        MemtoReg_out   <= r_cap_memtoreg;
                        ALUData_out    <= r_cap_alu;
                        WBregister_out <= r_cap_wbreg;
                        ReadData_out   <= mem_we ? '0 : mem_rdata;
                    end else if (w_timeout) begin
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: per-instruction reference model predicts stall
// length and the MEM/WB contents after every edge; a monitor pops and compares.
module tb_mem_access_stage;

    localparam int unsigned TO    = 4;
    localparam int          NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWrite_in = 1'b0, MemtoReg_in = 1'b0, MemRead_in = 1'b0, MemWrite_in = 1'b0;
    logic [31:0] ALUData_in = '0, MemWriteData_in = '0;
    logic [4:0]  WBregister_in = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        stall, mem_err;
    logic        RegWrite_out, MemtoReg_out;
    logic [31:0] ReadData_out, ALUData_out;
    logic [4:0]  WBregister_out;

    mem_access_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .ALUData_in(ALUData_in), .MemWriteData_in(MemWriteData_in),
        .WBregister_in(WBregister_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .mem_err(mem_err),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .ReadData_out(ReadData_out), .ALUData_out(ALUData_out),
        .WBregister_out(WBregister_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        err;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wb;
    } wb_t;

    wb_t   exp_q[$];
    int    nvec = 0;
    int    nerr = 0;
    int    mcnt = 0;
    int    cur_delay = NEVER;
    logic [31:0] cur_rdata = '0;
    logic  done = 1'b0;

    function automatic wb_t dut_wb();
        return '{RegWrite_out, MemtoReg_out, mem_err, ReadData_out, ALUData_out, WBregister_out};
    endfunction

    function automatic void chk(string name, logic [79:0] act, logic [79:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Variable-latency data memory: ack arrives `cur_delay` cycles after req first seen high.
    task automatic mem_step();
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_req) begin
            if (mcnt == cur_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = cur_rdata;
            end
            mcnt++;
        end else begin
            mcnt = 0;
        end
    endtask

    task automatic run_instr(input logic rw, input logic m2r, input logic mr, input logic mw,
                             input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wb,
                             input int delay, input logic [31:0] rdata);
        logic acc, mis, dual, acked, tmo;
        int   k;
        wb_t  e;
        acc   = mr | mw;
        mis   = acc && (alu % 4 != 0);
        dual  = mr & mw;
        acked = acc && !mis && (delay + 1 <= int'(TO));
        tmo   = acc && !mis && !acked;
        k     = (!acc || mis) ? 1 : (acked ? delay + 2 : int'(TO) + 1);
        mem_step();
        RegWrite_in = rw; MemtoReg_in = m2r; MemRead_in = mr; MemWrite_in = mw;
        ALUData_in = alu; MemWriteData_in = wd; WBregister_in = wb;
        cur_delay = delay; cur_rdata = rdata;
        for (int c = 0; c < k; c++) begin
            if (c > 0) mem_step();
            #1;
            chk("stall", 80'(stall), 80'(c < k - 1));
            chk("mem_req", 80'(mem_req), 80'(acc && !mis && c >= 1));
            if (acc && !mis && c >= 1)
                chk("req_fields", {15'd0, mem_we, mem_addr, mem_wdata},
                    {15'd0, !mr, alu, wd});
            e = '0;
            if (c == k - 1) begin
                if (!acc) e = '{rw, m2r, 1'b0, 32'd0, alu, wb};
                else if (acked) e = '{rw, m2r, 1'b0, mr ? rdata : 32'd0, alu, wb};
            end
            e.err = (c == 0 && (mis || dual)) || (tmo && c == k - 1);
            exp_q.push_back(e);
        end
    endtask

    initial begin : monitor
        wb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("mewb", 80'(dut_wb()), 80'(e));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

    initial begin : stim
        logic [3:0]  kind;
        logic [31:0] a;
        int          d;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_wb", 80'(dut_wb()), 80'd0);
        chk("reset_req_stall", {78'd0, mem_req, stall}, 80'd0);

        // Reset in the middle of an outstanding load.
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        MemRead_in = 1'b1; ALUData_in = 32'h40; WBregister_in = 5'd9; RegWrite_in = 1'b1;
        @(negedge clk); #1;
        chk("midwait_req", 80'(mem_req), 80'd1);
        @(negedge clk); #2;
        rst = 1'b0;
        MemRead_in = 1'b0; RegWrite_in = 1'b0; ALUData_in = '0; WBregister_in = '0;
        #1;
        chk("rst_req", {78'd0, mem_req, stall}, 80'd0);
        chk("rst_wb", 80'(dut_wb()), 80'd0);
        @(negedge clk); rst = 1'b1;
        RegWrite_in = 1'b1; ALUData_in = 32'h55; WBregister_in = 5'd3;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        #1;
        chk("late_ack_stall", 80'(stall), 80'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("late_ack_wb", 80'(dut_wb()), 80'({1'b1, 1'b0, 1'b0, 32'd0, 32'h55, 5'd3}));
        chk("late_ack_req", 80'(mem_req), 80'd0);

        // Directed cases.
        run_instr(1, 0, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 1, 32'h0);
        run_instr(1, 1, 1, 0, 32'h100, 32'h0, 5'd8, 3, 32'hDEADBEEF);
        run_instr(0, 0, 0, 1, 32'h200, 32'hCAFEF00D, 5'd0, 1, 32'h0);
        run_instr(1, 1, 1, 0, 32'h102, 32'h0, 5'd4, 1, 32'h0);
        run_instr(1, 1, 1, 0, 32'h300, 32'h0, 5'd6, NEVER, 32'h0);
        run_instr(1, 0, 0, 0, 32'h0000_0777, 32'h0, 5'd7, 1, 32'h0);
        run_instr(1, 1, 1, 1, 32'h400, 32'h1111_2222, 5'd2, 2, 32'h1357_9BDF);
        run_instr(1, 1, 1, 0, 32'h500, 32'h0, 5'd1, 1, 32'h0BAD_F00D);
        run_instr(1, 1, 1, 0, 32'h504, 32'h0, 5'd1, 1, 32'h600D_F00D);

        // Randomized stream.
        for (int n = 0; n < 300; n++) begin
            kind = 4'($urandom_range(0, 9));
            a    = $urandom;
            if ($urandom_range(0, 6) != 0) a[1:0] = 2'b00;
            d    = $urandom_range(1, 5);
            if (d == 5) d = NEVER;
            run_instr(1'($urandom), 1'($urandom),
                      kind inside {[4:6], 9}, kind inside {7, 8, 9},
                      a, $urandom, 5'($urandom), d, $urandom);
        end

        mem_step();
        RegWrite_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained", 80'(exp_q.size()), 80'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
